apb_rr_master_arb: RTL and testbench
====================================

Name: apb_rr_master_arb

Overview:
- Round-robin arbiter plus APB master sequencer. Lets NUM_REQ internal requesters share one APB slave, e.g. the team's word-addressed register/memory slave.
- Each requester issues single transfers over a valid/ready request port and gets a one-cycle response pulse.
- The block drives the IDLE/SETUP/ACCESS protocol and returns PRDATA/PSLVERR to the requester that owns the transfer.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 8, APB data width
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced abort (used only when the optional feature is compiled in)

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester transfer request
req_write  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, packed the same way
req_ready  out  NUM_REQ  one-hot accept; request i is taken when req_valid[i] && req_ready[i]
rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; valid only with rsp_valid
rsp_slverr  out  1  error flag; valid only with rsp_valid
PADDR  out  ADDR_WIDTH  APB address
PPROT  out  3  tied 3'b000
PNSE  out  1  tied 0
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  slave read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Reset values (asynchronous):
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid = 0; rsp_rdata = 0; rsp_slverr = 0.
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- All APB outputs and rsp_* are registered.
- req_ready is combinational: non-zero only in IDLE.
- Arbitration:
  - In IDLE with any req_valid set, the winner is the first set bit searching from last_grant+1 upward, with modulo-NUM_REQ wrap.
  - Only the winner sees req_ready=1.
  - On acceptance: latch addr/write/wdata, update last_grant to the winner, and store the owner index.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on acceptance. Next cycle PSEL=1, PENABLE=0, and PADDR/PWRITE/PWDATA take the latched values.
  - SETUP -> ACCESS unconditionally after one cycle. PSEL=1, PENABLE=1.
  - ACCESS holds while PREADY=0. PADDR/PWRITE/PWDATA/PSEL stay stable.
  - ACCESS -> IDLE on the edge where PREADY=1 is sampled:
    - PSEL and PENABLE go to 0.
    - rsp_valid[owner] pulses for exactly one cycle.
    - rsp_rdata = PRDATA for reads, 0 for writes; rsp_slverr = PSLVERR.
- Minimum transfer latency: acceptance at edge T; SETUP during T..T+1; ACCESS from T+1. With PREADY high on the first ACCESS cycle, rsp_valid is seen in cycle T+3.
- With a registered-PREADY slave, PREADY is first high on the second ACCESS cycle, so rsp_valid lands one cycle later.
- Back-to-back: the FSM always passes through IDLE for one cycle, so PSEL drops between transfers. A new acceptance is possible in the same cycle as the rsp_valid pulse.
- Requesters may drop req_valid before acceptance; nothing is committed. Request inputs are ignored outside IDLE.
- A requester may re-request immediately after its rsp_valid. Round-robin still serves every other pending requester first.
- Reset mid-transfer:
  - PSEL and PENABLE drop asynchronously.
  - The transfer is discarded; no rsp_valid is generated.
  - Arbitration restarts at requester 0.
- PSLVERR is sampled only in the PREADY=1 ACCESS cycle.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the FSM aborts to IDLE and PSEL/PENABLE drop.
  - rsp_valid[owner] pulses with rsp_slverr=1 and rsp_rdata=0.
  - A PREADY arriving in the same cycle as the limit wins and completes normally.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset, then req0 write addr 0x08 data 0xA5, slave PREADY on 2nd ACCESS cycle -> PSEL=1/PENABLE=0 one cycle, then PENABLE=1, PWRITE=1, PADDR=0x08, PWDATA=0xA5 stable; rsp_valid=2'b01, rsp_slverr=0.
- req1 read addr 0x08 after the above -> PWRITE=0; rsp_valid=2'b10, rsp_rdata=0xA5.
- req0 and req1 both asserted continuously after reset, 4 transfers -> grant order 0,1,0,1; PSEL low exactly one cycle between transfers.
- Slave returns PSLVERR=1 with PREADY -> rsp_slverr=1 for that one transfer only; next transfer rsp_slverr=0.
- PRESETn pulled low during ACCESS of a req1 transfer -> PSEL=0 immediately, no rsp_valid; after release, simultaneous req0/req1 -> req0 served first.
- APB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, PREADY held 0 -> PSEL drops after 16 ACCESS cycles; rsp_valid pulse with rsp_slverr=1, rsp_rdata=0x00.

Source files
------------

// File: rtl/apb_rr_master_arb_if.sv
// ----------------------------------------------------------------------------
// apb_rr_master_arb_if
// APB bus bundle between the round-robin APB master sequencer and its slave.
//
// Signals:
//   PADDR   master->slave  address
//   PPROT   master->slave  protection type (constant 3'b000 from this master)
//   PNSE    master->slave  non-secure extension (constant 0 from this master)
//   PSEL    master->slave  select
//   PENABLE master->slave  enable (second and later transfer cycles)
//   PWRITE  master->slave  1 = write, 0 = read
//   PWDATA  master->slave  write data
//   PRDATA  slave->master  read data
//   PREADY  slave->master  transfer completes when high in an ACCESS cycle
//   PSLVERR slave->master  error, meaningful only with PREADY
// Modports: master (used by apb_rr_master_arb), slave.
// ----------------------------------------------------------------------------
interface apb_rr_master_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [2:0]            PPROT;
   logic                  PNSE;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_rr_master_arb.sv
// ----------------------------------------------------------------------------
// apb_rr_master_arb
// Round-robin arbiter in front of an APB master sequencer. NUM_REQ internal
// requesters issue single transfers over valid/ready; the winner's request is
// run through IDLE -> SETUP -> ACCESS on the APB bus and the result comes back
// to that requester as a one-cycle rsp_valid pulse.
//
// Ports:
//   PCLK        clock
//   PRESETn     asynchronous active-low reset
//   req_valid   [NUM_REQ]              per-requester transfer request
//   req_write   [NUM_REQ]              1 = write, 0 = read
//   req_addr    [NUM_REQ*ADDR_WIDTH]   requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata   [NUM_REQ*DATA_WIDTH]   requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   [NUM_REQ]              one-hot accept (combinational, IDLE only)
//   rsp_valid   [NUM_REQ]              one-hot completion pulse
//   rsp_rdata   [DATA_WIDTH]           read data (0 for writes)
//   rsp_slverr                         slave error / timeout flag
//   apb                                APB master modport
//
// Compile-time option: APB_ARB_TIMEOUT_EN adds an ACCESS watchdog that aborts a
// transfer after TIMEOUT_CYCLES wait cycles and reports it as an error.
// ----------------------------------------------------------------------------
module apb_rr_master_arb #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_slverr,
   apb_rr_master_arb_if.master           apb
);
   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("apb_rr_master_arb: NUM_REQ must be 2..4");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_rr_master_arb: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                  state, state_next;
   logic [IDX_W-1:0]        last_grant_reg, last_grant_next;
   logic [IDX_W-1:0]        owner_reg, owner_next;
   logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
   logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
   logic                    pwrite_reg, pwrite_next;
   logic                    psel_reg, psel_next;
   logic                    penable_reg, penable_next;
   logic [NUM_REQ-1:0]      rsp_valid_reg, rsp_valid_next;
   logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
   logic                    rsp_slverr_reg, rsp_slverr_next;

   logic                    win_found;
   logic [IDX_W-1:0]        win_idx;
   logic                    accept;
   logic                    access_done;
   logic                    tmo_hit;
   int                      cand;

   // Rotating priority: scan last_grant+1, last_grant+2, ... with wrap; the
   // first requester seen with valid set wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_grant_reg) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign accept      = (state == IDLE) && win_found;
   assign access_done = (state == ACCESS) && apb.PREADY;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_idx] = 1'b1;
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] tmo_cnt_reg;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                             tmo_cnt_reg <= '0;
      else if (state == SETUP)                  tmo_cnt_reg <= '0;
      else if (state == ACCESS && !apb.PREADY)  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
   end

   // Abort on the edge at which the wait count would reach the limit; a
   // PREADY in that same cycle takes the normal completion path instead.
   assign tmo_hit = (state == ACCESS) && !apb.PREADY &&
                    (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (access_done || tmo_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values for every registered output
   always_comb begin
      last_grant_next = last_grant_reg;
      owner_next      = owner_reg;
      paddr_next      = paddr_reg;
      pwdata_next     = pwdata_reg;
      pwrite_next     = pwrite_reg;
      psel_next       = psel_reg;
      penable_next    = penable_reg;
      rsp_valid_next  = '0;
      rsp_rdata_next  = '0;
      rsp_slverr_next = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               last_grant_next = win_idx;
               owner_next      = win_idx;
               paddr_next      = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               pwdata_next     = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
               pwrite_next     = req_write[win_idx];
               psel_next       = 1'b1;
               penable_next    = 1'b0;
            end
         end
         SETUP: begin
            penable_next = 1'b1;
         end
         ACCESS: begin
            if (access_done) begin
               psel_next                 = 1'b0;
               penable_next              = 1'b0;
               rsp_valid_next[owner_reg] = 1'b1;
               rsp_rdata_next            = pwrite_reg ? '0 : apb.PRDATA;
               rsp_slverr_next           = apb.PSLVERR;
            end else if (tmo_hit) begin
               psel_next                 = 1'b0;
               penable_next              = 1'b0;
               rsp_valid_next[owner_reg] = 1'b1;
               rsp_slverr_next           = 1'b1;
            end
         end
         default: begin
            psel_next    = 1'b0;
            penable_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         last_grant_reg <= IDX_W'(NUM_REQ - 1);
         owner_reg      <= '0;
         paddr_reg      <= '0;
         pwdata_reg     <= '0;
         pwrite_reg     <= 1'b0;
         psel_reg       <= 1'b0;
         penable_reg    <= 1'b0;
         rsp_valid_reg  <= '0;
         rsp_rdata_reg  <= '0;
         rsp_slverr_reg <= 1'b0;
      end else begin
         last_grant_reg <= last_grant_next;
         owner_reg      <= owner_next;
         paddr_reg      <= paddr_next;
         pwdata_reg     <= pwdata_next;
         pwrite_reg     <= pwrite_next;
         psel_reg       <= psel_next;
         penable_reg    <= penable_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_rdata_reg  <= rsp_rdata_next;
         rsp_slverr_reg <= rsp_slverr_next;
      end
   end

   assign apb.PADDR   = paddr_reg;
   assign apb.PWDATA  = pwdata_reg;
   assign apb.PWRITE  = pwrite_reg;
   assign apb.PSEL    = psel_reg;
   assign apb.PENABLE = penable_reg;
   assign apb.PPROT   = 3'b000;
   assign apb.PNSE    = 1'b0;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rsp_rdata_reg;
   assign rsp_slverr  = rsp_slverr_reg;
endmodule

// File: tb/tb_apb_rr_master_arb.sv
// ----------------------------------------------------------------------------
// tb_apb_rr_master_arb
// Randomized bench for apb_rr_master_arb with a transaction-level model:
// the stimulus process decides grants from the round-robin rule, pushes the
// expected APB transfer and the expected response into queues, and a separate
// monitor process checks the APB bus and the rsp_* pulses against them.
// Build with APB_ARB_TIMEOUT_EN to add the watchdog abort scenario.
// ----------------------------------------------------------------------------
module tb_apb_rr_master_arb;
   localparam int NR  = 2;
   localparam int AW  = 32;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic                PCLK    = 1'b0;
   logic                PRESETn = 1'b0;
   logic [NR-1:0]       req_valid = '0;
   logic [NR-1:0]       req_write = '0;
   logic [NR*AW-1:0]    req_addr  = '0;
   logic [NR*DW-1:0]    req_wdata = '0;
   logic [NR-1:0]       req_ready;
   logic [NR-1:0]       rsp_valid;
   logic [DW-1:0]       rsp_rdata;
   logic                rsp_slverr;

   apb_rr_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_rr_master_arb #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
      .apb(apb)
   );

   initial forever #5 PCLK = ~PCLK;

   typedef struct { int owner; logic [DW-1:0] rdata; logic err; } rsp_t;
   typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } apb_t;
   typedef struct { int id; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } dir_t;

   rsp_t  rsp_q[$];
   apb_t  apb_q[$];
   dir_t  dir_q[$];

   int    n_cmp = 0;
   int    n_err = 0;

   // reference model state
   int    last_grant = NR - 1;
   bit    idle = 1'b1;
   bit    pending [NR];
   bit    accepted_last = 1'b0;
   int    acc_w = 0;
   int    mode = 0;          // 0 directed, 1 random, 2 all requesters always on
   int    mode2_grants = 0;
   bit    hold_low = 1'b0;   // slave withholds PREADY
   int    slv_wait = 0;
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] slv_mem [256];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_err(input logic [AW-1:0] a);
      return a[7:4] == 4'hF;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < NR; i++) if (pending[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a[7:0] = 8'hF0 | 8'($urandom_range(0, 3));
      else                           a[7:0] = 8'($urandom_range(0, 7));
      return a;
   endfunction

   task automatic new_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pending[i]              = 1'b1;
      req_valid[i]            = 1'b1;
      req_write[i]            = wr;
      req_addr[i*AW +: AW]    = a;
      req_wdata[i*DW +: DW]   = d;
   endtask

   task automatic accept(input int w);
      apb_t t;
      rsp_t r;
      t.addr  = req_addr[w*AW +: AW];
      t.wr    = req_write[w];
      t.wdata = req_wdata[w*DW +: DW];
      r.owner = w;
      if (hold_low) begin
         r.err   = 1'b1;
         r.rdata = '0;
      end else begin
         r.err   = is_err(t.addr);
         r.rdata = t.wr ? '0 : ref_mem[t.addr[7:0]];
         if (t.wr && !r.err) ref_mem[t.addr[7:0]] = t.wdata;
      end
      apb_q.push_back(t);
      rsp_q.push_back(r);
      last_grant    = w;
      accepted_last = 1'b1;
      acc_w         = w;
      if (mode == 2) begin
         mode2_grants++;
         if (mode2_grants == 4) mode = 0;
      end
   endtask

   // One clock cycle: update model, drive slave and requesters, check grant.
   task automatic step();
      logic          rdy;
      logic [NR-1:0] exp_ready;
      int            w;
      int            cand;
      dir_t          d;
      @(posedge PCLK);
      #1;
      if (accepted_last) begin
         pending[acc_w]   = 1'b0;
         req_valid[acc_w] = 1'b0;
         accepted_last    = 1'b0;
         idle             = 1'b0;
      end
      if (rsp_valid != '0) idle = 1'b1;

      if (apb.PSEL && apb.PENABLE) begin
         rdy = hold_low ? 1'b0 : 1'($urandom_range(0, 1));
`ifdef APB_ARB_TIMEOUT_EN
         if (!hold_low && slv_wait >= 8) rdy = 1'b1;
`endif
         apb.PREADY  = rdy;
         apb.PRDATA  = slv_mem[apb.PADDR[7:0]];
         apb.PSLVERR = is_err(apb.PADDR);
         if (rdy) begin
            if (apb.PWRITE && !is_err(apb.PADDR)) slv_mem[apb.PADDR[7:0]] = apb.PWDATA;
            slv_wait = 0;
         end else begin
            slv_wait++;
         end
      end else begin
         apb.PREADY  = 1'($urandom_range(0, 1));
         apb.PRDATA  = DW'($urandom);
         apb.PSLVERR = 1'($urandom_range(0, 1));
         slv_wait    = 0;
      end

      case (mode)
         0: while (dir_q.size() > 0 && !pending[dir_q[0].id]) begin
               d = dir_q.pop_front();
               new_req(d.id, d.wr, d.addr, d.data);
            end
         1: for (int i = 0; i < NR; i++) begin
               if (pending[i]) begin
                  if ($urandom_range(0, 15) == 0) begin
                     pending[i]   = 1'b0;
                     req_valid[i] = 1'b0;
                  end
               end else if ($urandom_range(0, 99) < 30) begin
                  new_req(i, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
               end
            end
         default: for (int i = 0; i < NR; i++)
               if (!pending[i]) new_req(i, 1'b1, AW'(32'h40 + i), DW'($urandom));
      endcase
      #1;

      exp_ready = '0;
      w = -1;
      if (idle && PRESETn) begin
         for (int k = 1; k <= NR; k++) begin
            cand = (last_grant + k) % NR;
            if (w < 0 && req_valid[cand]) w = cand;
         end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (w >= 0) accept(w);
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while ((dir_q.size() != 0 || rsp_q.size() != 0 || accepted_last || any_pending() || !idle)
             && n < max_cycles) begin
         step();
         n++;
      end
      if (n >= max_cycles) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
      end
   endtask

   // monitor state
   bit   done_prev = 1'b0;
   bit   prev_psel = 1'b0;
   bit   have_end2 = 1'b0;
   int   gap = 0;
   int   acc_n = 0;
   apb_t cur;

   initial begin : monitor
      rsp_t e;
      bit   done_now;
      bit   limit;
      forever begin
         @(negedge PCLK);
         if (!PRESETn) begin
            chk("reset_psel", 64'(apb.PSEL), 64'(0));
            chk("reset_penable", 64'(apb.PENABLE), 64'(0));
            chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
            done_prev = 1'b0;
            prev_psel = 1'b0;
            have_end2 = 1'b0;
            gap       = 0;
            acc_n     = 0;
            continue;
         end

         if (done_prev) begin
            if (rsp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp_unexpected: got rsp_valid=0x%0h, expected no transfer", rsp_valid);
            end else begin
               e = rsp_q.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.owner);
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("rsp_slverr", 64'(rsp_slverr), 64'(e.err));
               $display("rsp  owner=%0d rsp_valid=%b rdata=0x%02h slverr=%0d t=%0t",
                        e.owner, rsp_valid, rsp_rdata, rsp_slverr, $time);
            end
            chk("psel_drop", 64'(apb.PSEL), 64'(0));
         end else begin
            chk("rsp_quiet", 64'(rsp_valid), 64'(0));
         end

         if (apb.PSEL && !apb.PENABLE) begin
            chk("setup_after_idle", 64'(prev_psel), 64'(0));
            if (have_end2) chk("idle_gap", 64'(gap), 64'(1));
            have_end2 = 1'b0;
            acc_n     = 0;
            if (apb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL apb_unexpected: got PSEL=1 PADDR=0x%0h, expected no transfer", apb.PADDR);
            end else begin
               cur = apb_q.pop_front();
               chk("setup_paddr", 64'(apb.PADDR), 64'(cur.addr));
               chk("setup_pwrite", 64'(apb.PWRITE), 64'(cur.wr));
               if (cur.wr) chk("setup_pwdata", 64'(apb.PWDATA), 64'(cur.wdata));
            end
         end else if (apb.PSEL && apb.PENABLE) begin
            chk("access_after_select", 64'(prev_psel), 64'(1));
            chk("access_paddr", 64'(apb.PADDR), 64'(cur.addr));
            chk("access_pwrite", 64'(apb.PWRITE), 64'(cur.wr));
            if (cur.wr) chk("access_pwdata", 64'(apb.PWDATA), 64'(cur.wdata));
         end else begin
            chk("penable_idle", 64'(apb.PENABLE), 64'(0));
         end

         limit = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         limit = (acc_n == TMO - 1);
`endif
         done_now = apb.PSEL && apb.PENABLE && (apb.PREADY || limit);
         if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc_n++;
         if (!apb.PSEL) gap++;
         if (done_now) begin
            gap       = 0;
            have_end2 = (mode == 2);
         end
         prev_psel = apb.PSEL;
         done_prev = done_now;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'(i) ^ 8'h5A;
         slv_mem[i] = 8'(i) ^ 8'h5A;
      end
      for (int i = 0; i < NR; i++) pending[i] = 1'b0;
      apb.PREADY  = 1'b0;
      apb.PRDATA  = '0;
      apb.PSLVERR = 1'b0;

      repeat (3) @(posedge PCLK);
      #3;
      chk("rst_paddr", 64'(apb.PADDR), 64'(0));
      chk("rst_pwdata", 64'(apb.PWDATA), 64'(0));
      chk("rst_pwrite", 64'(apb.PWRITE), 64'(0));
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_rsp_slverr", 64'(rsp_slverr), 64'(0));
      chk("rst_pprot", 64'(apb.PPROT), 64'(0));
      chk("rst_pnse", 64'(apb.PNSE), 64'(0));
      PRESETn = 1'b1;

      // directed: write then read back, error then clean
      mode = 0;
      dir_q.push_back('{0, 1'b1, 32'h08, 8'hA5}); drain(100);
      dir_q.push_back('{1, 1'b0, 32'h08, 8'h00}); drain(100);
      dir_q.push_back('{0, 1'b1, 32'hF4, 8'h3C}); drain(100);
      dir_q.push_back('{1, 1'b0, 32'h08, 8'h00}); drain(100);

      // both requesters always on: alternating grants, one idle cycle between
      mode2_grants = 0;
      mode = 2;
      n = 0;
      while (mode == 2 && n < 200) begin
         step();
         n++;
      end
      mode = 0;
      drain(200);

      // randomized traffic
      mode = 1;
      repeat (800) step();
      mode = 0;
      drain(300);

      // reset in the middle of a requester-1 transfer
      hold_low = 1'b1;
      dir_q.push_back('{1, 1'b0, 32'h10, 8'h00});
      n = 0;
      do begin
         step();
         n++;
      end while (!(apb.PSEL && apb.PENABLE) && n < 20);
      if (n >= 20) begin
         n_cmp++;
         n_err++;
         $display("FAIL reach_access: no ACCESS phase within %0d cycles", n);
      end
      step();
      PRESETn = 1'b0;
      #1;
      chk("async_psel", 64'(apb.PSEL), 64'(0));
      chk("async_penable", 64'(apb.PENABLE), 64'(0));
      rsp_q.delete();
      apb_q.delete();
      last_grant    = NR - 1;
      idle          = 1'b1;
      accepted_last = 1'b0;
      hold_low      = 1'b0;
      for (int i = 0; i < NR; i++) pending[i] = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge PCLK);
      @(posedge PCLK);
      #3;
      PRESETn = 1'b1;
      dir_q.push_back('{0, 1'b0, 32'h08, 8'h00});
      dir_q.push_back('{1, 1'b0, 32'h03, 8'h00});
      drain(100);

`ifdef APB_ARB_TIMEOUT_EN
      // slave never answers: watchdog abort with error
      hold_low = 1'b1;
      dir_q.push_back('{0, 1'b0, 32'h30, 8'h00});
      drain(100);
      hold_low = 1'b0;
      dir_q.push_back('{1, 1'b0, 32'h08, 8'h00});
      drain(100);
`endif

      repeat (4) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
